// File: rtl/car_request_conditioner.sv
// Conditions the country-road loop sensor into a car-waiting request for the traffic signal
// controller, with a waiting-car count and min/max country-green and highway-green timing.
module car_request_conditioner #(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned CAR_CYCLES = 8,
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MAX_GREEN  = 32,
  parameter int unsigned HW_MIN     = 16,
  parameter int unsigned CW         = 4
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          sensor_raw,
  input  logic          country_green,
  output logic          signal,
  output logic [CW-1:0] car_count,
  output logic [1:0]    fsm_state,
  output logic          timeout
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE + 1);
  localparam int unsigned DepW   = $clog2(CAR_CYCLES + 1);
  localparam int unsigned ServeW = $clog2(MAX_GREEN + 1);
  localparam int unsigned CoolW  = $clog2(HW_MIN + 1);

  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE - 1);
  localparam logic [DepW-1:0]   DepLast   = DepW'(CAR_CYCLES - 1);
  localparam logic [ServeW-1:0] ServeLast = ServeW'(MAX_GREEN - 1);
  localparam logic [ServeW-1:0] MinLast   = ServeW'(MIN_GREEN - 1);
  localparam logic [CoolW-1:0]  CoolLast  = CoolW'(HW_MIN - 1);
  localparam logic [CW-1:0]     CountMax  = '1;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRequest  = 2'd1,
    StServe    = 2'd2,
    StCooldown = 2'd3
  } state_e;

  logic              meta_q, sync_q;
  logic              db_q, db_d, db_prev_q;
  logic [DbW-1:0]    db_cnt_q, db_cnt_d;
  logic [DepW-1:0]   dep_q, dep_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ServeW-1:0] serve_q, serve_d;
  logic [CoolW-1:0]  cool_q, cool_d;
  logic              timeout_q, timeout_d;
  state_e            state_q, state_d;
  logic              arrival, dep_tick;

  // A level change is accepted only after DEBOUNCE consecutive differing cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync_q != db_q) begin
      if (db_cnt_q == DbLast) begin
        db_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign arrival  = db_q & ~db_prev_q;
  assign dep_tick = country_green && (dep_q == DepLast);

  always_comb begin
    dep_d = '0;
    if (country_green && !dep_tick) begin
      dep_d = dep_q + 1'b1;
    end
  end

  // Arrival and departure in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({arrival, dep_tick})
      2'b10:   if (count_q != CountMax) count_d = count_q + 1'b1;
      2'b01:   if (count_q != '0)       count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    serve_d   = serve_q;
    cool_d    = cool_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StRequest;
      end
      StRequest: begin
        if (country_green) begin
          state_d = StServe;
          serve_d = '0;
        end
      end
      StServe: begin
        if (serve_q == ServeLast) begin
          state_d   = StCooldown;
          cool_d    = '0;
          timeout_d = 1'b1;
        end else if ((count_q == '0) && (serve_q >= MinLast)) begin
          state_d = StCooldown;
          cool_d  = '0;
        end else if (!country_green) begin
          state_d = StCooldown;
          cool_d  = '0;
        end else begin
          serve_d = serve_q + 1'b1;
        end
      end
      StCooldown: begin
        // Only highway-green time counts towards the minimum highway interval.
        if (!country_green) begin
          if (cool_q == CoolLast) begin
            state_d = StIdle;
          end else begin
            cool_d = cool_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
      dep_q     <= '0;
      count_q   <= '0;
      serve_q   <= '0;
      cool_q    <= '0;
      timeout_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      meta_q    <= sensor_raw;
      sync_q    <= meta_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
      dep_q     <= dep_d;
      count_q   <= count_d;
      serve_q   <= serve_d;
      cool_q    <= cool_d;
      timeout_q <= timeout_d;
      state_q   <= state_d;
    end
  end

  assign signal    = (state_q == StRequest) || (state_q == StServe);
  assign car_count = count_q;
  assign fsm_state = state_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_car_request_conditioner.sv
// Directed bench for car_request_conditioner with default parameters and cycle-exact checks.
module tb_car_request_conditioner;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       sensor_raw;
  logic       country_green;
  logic       signal;
  logic [3:0] car_count;
  logic [1:0] fsm_state;
  logic       timeout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  car_request_conditioner dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .sensor_raw    (sensor_raw),
    .country_green (country_green),
    .signal        (signal),
    .car_count     (car_count),
    .fsm_state     (fsm_state),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clean car: long enough high and low to pass the debouncer both ways.
  task automatic arrive();
    sensor_raw = 1'b1;
    step(6);
    sensor_raw = 1'b0;
    step(7);
  endtask

  initial begin
    clear_n       = 1'b0;
    sensor_raw    = 1'b0;
    country_green = 1'b0;
    step(3);
    clear_n = 1'b1;
    check("rst_state", fsm_state, 0);
    check("rst_signal", signal, 0);
    check("rst_count", car_count, 0);
    check("rst_timeout", timeout, 0);

    // Short glitch is rejected.
    sensor_raw = 1'b1;
    step(3);
    sensor_raw = 1'b0;
    step(12);
    check("glitch_count", car_count, 0);
    check("glitch_signal", signal, 0);

    // 10-cycle pulse: count at k+6, request at k+7.
    sensor_raw = 1'b1;
    step(6);
    check("arr_count_k5", car_count, 0);
    step(1);
    check("arr_count_k6", car_count, 1);
    check("arr_signal_k6", signal, 0);
    step(1);
    check("arr_signal_k7", signal, 1);
    check("arr_state_k7", fsm_state, 1);
    step(2);
    sensor_raw = 1'b0;
    step(8);

    // Normal service of one car.
    country_green = 1'b1;
    step(1);
    check("srv_state", fsm_state, 2);
    check("srv_signal", signal, 1);
    step(6);
    check("srv_count_pre", car_count, 1);
    step(1);
    check("srv_count_tick", car_count, 0);
    check("srv_state_hold", fsm_state, 2);
    step(1);
    check("srv_end_state", fsm_state, 3);
    check("srv_end_signal", signal, 0);
    check("srv_end_timeout", timeout, 0);
    country_green = 1'b0;
    step(1);
    check("srv_timeout_after", timeout, 0);
    step(15);
    check("srv_cool_idle", fsm_state, 0);
    check("srv_idle_signal", signal, 0);

    // Max green with 15 cars waiting.
    repeat (15) arrive();
    check("max_count_in", car_count, 15);
    check("max_state_req", fsm_state, 1);
    country_green = 1'b1;
    step(1);
    check("max_state_serve", fsm_state, 2);
    step(31);
    check("max_count_31", car_count, 11);
    check("max_state_31", fsm_state, 2);
    check("max_timeout_31", timeout, 0);
    step(1);
    check("max_state_cut", fsm_state, 3);
    check("max_signal_cut", signal, 0);
    check("max_timeout_pulse", timeout, 1);
    check("max_count_left", car_count, 11);
    country_green = 1'b0;
    step(1);
    check("max_timeout_clear", timeout, 0);
    step(14);
    check("max_cool_hold", fsm_state, 3);
    step(1);
    check("max_cool_idle", fsm_state, 0);
    step(1);
    check("max_rereq_state", fsm_state, 1);
    check("max_rereq_signal", signal, 1);

    // Saturation: 11 + 6 arrivals caps at 15.
    repeat (3) arrive();
    check("sat_count_14", car_count, 14);
    repeat (3) arrive();
    check("sat_count_15", car_count, 15);

    // Arrival coinciding with a departure tick.
    country_green = 1'b1;
    step(1);
    check("sim_state", fsm_state, 2);
    step(7);
    check("sim_first_tick", car_count, 14);
    step(1);
    sensor_raw = 1'b1;
    step(6);
    check("sim_count_pre", car_count, 14);
    sensor_raw = 1'b0;
    step(1);
    check("sim_count_both", car_count, 14);
    country_green = 1'b0;
    step(1);
    check("sim_withdraw_state", fsm_state, 3);
    check("sim_withdraw_count", car_count, 14);

    // Early withdrawal at serve cycle 2.
    step(17);
    check("ew_req_state", fsm_state, 1);
    country_green = 1'b1;
    step(2);
    check("ew_serve_state", fsm_state, 2);
    country_green = 1'b0;
    step(1);
    check("ew_state", fsm_state, 3);
    check("ew_signal", signal, 0);
    check("ew_timeout", timeout, 0);
    check("ew_count", car_count, 14);

    // Reset in the middle of a serve phase.
    step(17);
    country_green = 1'b1;
    step(3);
    check("mr_serve_state", fsm_state, 2);
    clear_n = 1'b0;
    step(3);
    clear_n       = 1'b1;
    country_green = 1'b0;
    check("mr_state", fsm_state, 0);
    check("mr_signal", signal, 0);
    check("mr_count", car_count, 0);
    check("mr_timeout", timeout, 0);
    step(2);
    check("mr_state_stay", fsm_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/car_request_conditioner.md
# car_request_conditioner

Front-end stage feeding the traffic signal controller's `signal` input. Synchronises and debounces the raw country-road loop sensor and counts waiting cars. It raises the car-waiting request to the controller and keeps it up while cars remain, subject to minimum and maximum country-green times. After each country-green phase it enforces a minimum highway-green interval before it requests again.

## Interface
- `DEBOUNCE`, default 4: consecutive stable cycles needed to accept a sensor level change (≥1).
- `CAR_CYCLES`, default 8: country-green cycles credited as one car departure (≥1).
- `MIN_GREEN`, default 4: minimum cycles the request is held once country green is seen.
- `MAX_GREEN`, default 32: maximum cycles of request while country green (> `MIN_GREEN`).
- `HW_MIN`, default 16: minimum cycles of country-not-green after a phase before a new request.
- `CW`, default 4: width of the car counter.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `clear_n`, input, 1: synchronous, active-low reset.
- `sensor_raw`, input, 1: asynchronous loop-detector level, high while a car is over the loop.
- `country_green`, input, 1: high while the controller shows country-road GREEN (country-road lamp bit 0).
- `signal`, output, 1: car-waiting request to the controller.
- `car_count`, output, CW: number of cars waiting or being served.
- `fsm_state`, output, 2: IDLE=0, REQUEST=1, SERVE=2, COOLDOWN=3.
- `timeout`, output, 1: one-cycle pulse when SERVE is cut off by `MAX_GREEN`.

## Operation
- **Input conditioning**
  - `sensor_raw` passes through a 2-flop synchroniser to give `sync`.
  - Debounce counter: while `sync` != `sensor_db`, count; when the count reaches `DEBOUNCE`, `sensor_db` <= `sync` and the count clears. Any cycle with `sync` == `sensor_db` clears the count.
- **Arrivals:** a rising edge of `sensor_db` is an arrival; `car_count` increments and saturates at 2^CW-1.
- **Departures:**
  - A departure timer counts only while `country_green`=1 and clears whenever `country_green`=0.
  - When it reaches `CAR_CYCLES`-1 it emits a tick and wraps to 0.
  - Each tick decrements `car_count`, saturating at 0.
  - An arrival and a tick in the same cycle leave `car_count` unchanged.
- **State machine** (`signal` = state is REQUEST or SERVE, decoded directly from the state register):
  - IDLE: if `car_count`>0, go to REQUEST.
  - REQUEST: if `country_green`=1, go to SERVE and clear `serve_t`.
  - SERVE: `serve_t` increments each cycle. Go to COOLDOWN when any of these hold:
    - `serve_t`==`MAX_GREEN`-1; pulse `timeout`.
    - `car_count`==0 and `serve_t`>=`MIN_GREEN`-1.
    - `country_green` drops early (controller override); no `timeout`.
  - COOLDOWN: `cool_t` clears on entry and increments only while `country_green`=0. When `cool_t` reaches `HW_MIN`-1, go to IDLE.
- **Remaining cars:** cars still counted after a `MAX_GREEN` cut-off stay in `car_count`. IDLE then re-requests immediately.
- **Reset:** `clear_n`=0 at a rising edge forces the following, regardless of state, with priority over all other events:
  - state IDLE, `signal`=0, `car_count`=0, `timeout`=0, `fsm_state`=0;
  - all timers, debounce count, `sensor_db` and synchroniser flops cleared to 0.

## Timing
- `sensor_raw` rises before edge k and stays high:
  - `sync` goes high at edge k+1;
  - `sensor_db` goes high at edge k+1+`DEBOUNCE`;
  - `car_count` increments at edge k+2+`DEBOUNCE`;
  - state becomes REQUEST and `signal`=1 at edge k+3+`DEBOUNCE`.
- Glitches shorter than `DEBOUNCE` cycles at `sync` are rejected entirely.
- SERVE duration, in edges from entry to COOLDOWN:
  - at least `MIN_GREEN` when country green is not withdrawn;
  - at most `MAX_GREEN`.
- `signal` falls on the same edge that enters COOLDOWN.
- The earliest re-request comes `HW_MIN` country-not-green cycles after COOLDOWN entry, plus one edge through IDLE.
- `timeout` is high for exactly the cycle after the SERVE→COOLDOWN edge caused by `MAX_GREEN`.
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.

## Test plan
- Reset: hold `clear_n`=0 for 3 cycles mid-SERVE with `car_count`=5 → next cycle state IDLE, `signal`=0, `car_count`=0, `timeout`=0.
- Debounce: 3-cycle `sensor_raw` pulse (`DEBOUNCE`=4) → `car_count` stays 0 and `signal` stays 0; a 10-cycle pulse → `car_count`=1 at edge k+6, `signal`=1 at edge k+7.
- Normal service: 1 car, assert `country_green` 2 cycles after `signal` → SERVE; tick after 8 cycles sets `car_count`=0; `signal` falls at SERVE cycle 8; `timeout` never pulses.
- Max green: 15 arrivals, `country_green` held high → `signal` drops after 32 SERVE cycles; `timeout` pulses once; `car_count`=11; after 16 cycles with `country_green`=0, state IDLE then REQUEST.
- Saturation and simultaneity: 17 arrivals with CW=4 → `car_count`=15. Arrival coinciding with a departure tick → count unchanged.
- Early withdrawal: drop `country_green` at SERVE cycle 2 → COOLDOWN next edge, `signal`=0, `timeout`=0, cars retained.
